// File: rtl/snitch_icache_pkg.sv
`default_nettype none
// ============================================================================
// snitch_icache_pkg: shared instruction-cache configuration record.
// Rev 1.0
// ============================================================================
package snitch_icache_pkg;

  typedef struct packed {
    logic [31:0] FETCH_AW;
    logic [31:0] ID_WIDTH;
    logic [31:0] LINE_WIDTH;
    logic [31:0] LINE_ALIGN;
    logic [31:0] COUNT_ALIGN;
    logic [31:0] SET_ALIGN;
    logic [31:0] WAY_COUNT;
    logic [31:0] TAG_WIDTH;
  } config_t;

  // 32-bit fetch address, 64-bit lines, 16 lines per way, 4 ways.
  localparam config_t DEFAULT_CFG = '{
    FETCH_AW:    32'd32,
    ID_WIDTH:    32'd4,
    LINE_WIDTH:  32'd64,
    LINE_ALIGN:  32'd3,
    COUNT_ALIGN: 32'd4,
    SET_ALIGN:   32'd2,
    WAY_COUNT:   32'd4,
    TAG_WIDTH:   32'd25
  };

endpackage
`default_nettype wire

// File: rtl/snitch_icache_lookup_refiller_if.sv
`default_nettype none
// ============================================================================
// snitch_icache_lookup_refiller_if: lookup, response, refill and write buses.
// Rev 1.0
// ============================================================================
interface snitch_icache_lookup_refiller_if #(
  parameter snitch_icache_pkg::config_t CFG = snitch_icache_pkg::DEFAULT_CFG
);
  logic [CFG.FETCH_AW-1:0]   lookup_addr_i;
  logic [CFG.ID_WIDTH-1:0]   lookup_id_i;
  logic [CFG.SET_ALIGN-1:0]  lookup_set_i;
  logic                      lookup_hit_i;
  logic [CFG.LINE_WIDTH-1:0] lookup_data_i;
  logic                      lookup_error_i;
  logic                      lookup_valid_i;
  logic                      lookup_ready_o;

  logic [CFG.LINE_WIDTH-1:0] rsp_data_o;
  logic                      rsp_error_o;
  logic [CFG.ID_WIDTH-1:0]   rsp_id_o;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;

  logic [CFG.FETCH_AW-1:0]   refill_addr_o;
  logic                      refill_valid_o;
  logic                      refill_ready_i;

  logic [CFG.LINE_WIDTH-1:0] refill_data_i;
  logic                      refill_error_i;
  logic                      refill_valid_i;
  logic                      refill_ready_o;

  logic [CFG.COUNT_ALIGN-1:0] write_addr_o;
  logic [CFG.SET_ALIGN-1:0]   write_set_o;
  logic [CFG.LINE_WIDTH-1:0]  write_data_o;
  logic [CFG.TAG_WIDTH-1:0]   write_tag_o;
  logic                       write_error_o;
  logic                       write_valid_o;
  logic                       write_ready_i;

  modport master (
    input  lookup_addr_i, lookup_id_i, lookup_set_i, lookup_hit_i,
    input  lookup_data_i, lookup_error_i, lookup_valid_i,
    output lookup_ready_o,
    output rsp_data_o, rsp_error_o, rsp_id_o, rsp_valid_o,
    input  rsp_ready_i,
    output refill_addr_o, refill_valid_o,
    input  refill_ready_i,
    input  refill_data_i, refill_error_i, refill_valid_i,
    output refill_ready_o,
    output write_addr_o, write_set_o, write_data_o, write_tag_o,
    output write_error_o, write_valid_o,
    input  write_ready_i
  );

  modport slave (
    output lookup_addr_i, lookup_id_i, lookup_set_i, lookup_hit_i,
    output lookup_data_i, lookup_error_i, lookup_valid_i,
    input  lookup_ready_o,
    input  rsp_data_o, rsp_error_o, rsp_id_o, rsp_valid_o,
    output rsp_ready_i,
    input  refill_addr_o, refill_valid_o,
    output refill_ready_i,
    output refill_data_i, refill_error_i, refill_valid_i,
    input  refill_ready_o,
    input  write_addr_o, write_set_o, write_data_o, write_tag_o,
    input  write_error_o, write_valid_o,
    output write_ready_i
  );

endinterface
`default_nettype wire

// File: rtl/snitch_icache_lookup_refiller.sv
`default_nettype none
// ============================================================================
// snitch_icache_lookup_refiller: forwards L1 hits, refills one miss at a time.
// Rev 1.0
// ============================================================================
module snitch_icache_lookup_refiller
  import snitch_icache_pkg::*;
#(
  parameter config_t CFG = DEFAULT_CFG
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  snitch_icache_lookup_refiller_if.master bus
);

  localparam int unsigned FETCH_AW    = CFG.FETCH_AW;
  localparam int unsigned ID_WIDTH    = CFG.ID_WIDTH;
  localparam int unsigned LINE_WIDTH  = CFG.LINE_WIDTH;
  localparam int unsigned LINE_ALIGN  = CFG.LINE_ALIGN;
  localparam int unsigned COUNT_ALIGN = CFG.COUNT_ALIGN;
  localparam int unsigned SET_ALIGN   = CFG.SET_ALIGN;
  localparam int unsigned WAY_COUNT   = CFG.WAY_COUNT;
  localparam int unsigned LINE_AW     = FETCH_AW - LINE_ALIGN;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e                  state_q;
  logic [LINE_AW-1:0]      line_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [LINE_WIDTH-1:0]   data_q;
  logic                    error_q;
  logic [SET_ALIGN-1:0]    victim_q;
  logic                    refill_valid_q;
  logic                    refill_ready_q;
  logic                    write_valid_q;
  logic                    rsp_valid_q;
  logic                    write_hs;

  assign write_hs = write_valid_q & bus.write_ready_i;

  // Only the line address of a miss is kept; the byte offset never matters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      line_q         <= '0;
      id_q           <= '0;
      data_q         <= '0;
      error_q        <= 1'b0;
      refill_valid_q <= 1'b0;
      refill_ready_q <= 1'b0;
      write_valid_q  <= 1'b0;
      rsp_valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.lookup_valid_i && !bus.lookup_hit_i) begin
            line_q         <= bus.lookup_addr_i[FETCH_AW-1:LINE_ALIGN];
            id_q           <= bus.lookup_id_i;
            refill_valid_q <= 1'b1;
            state_q        <= REQ;
          end
        end
        REQ: begin
          if (bus.refill_ready_i) begin
            refill_valid_q <= 1'b0;
            refill_ready_q <= 1'b1;
            state_q        <= WAIT;
          end
        end
        WAIT: begin
          if (bus.refill_valid_i) begin
            data_q         <= bus.refill_data_i;
            error_q        <= bus.refill_error_i;
            refill_ready_q <= 1'b0;
            write_valid_q  <= 1'b1;
            state_q        <= WRITE;
          end
        end
        WRITE: begin
          if (bus.write_ready_i) begin
            write_valid_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  if (WAY_COUNT > 1) begin : g_round_robin
    localparam logic [SET_ALIGN-1:0] LAST_WAY = SET_ALIGN'(WAY_COUNT - 1);

    // Flush wins over a simultaneous write-handshake increment.
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        victim_q <= '0;
      end else if (write_hs) begin
        victim_q <= (victim_q == LAST_WAY) ? '0 : victim_q + 1'b1;
      end
    end
  end else begin : g_single_way
    logic unused_flush;
    assign unused_flush = flush_i ^ write_hs;
    assign victim_q     = '0;
  end

  logic idle;
  assign idle = (state_q == IDLE);

  assign bus.lookup_ready_o = !rst_i && idle &&
                              (!bus.lookup_valid_i || !bus.lookup_hit_i || bus.rsp_ready_i);

  assign bus.rsp_valid_o = !rst_i &&
                           (rsp_valid_q || (idle && bus.lookup_valid_i && bus.lookup_hit_i));
  assign bus.rsp_data_o  = rsp_valid_q ? data_q  : bus.lookup_data_i;
  assign bus.rsp_error_o = rsp_valid_q ? error_q : bus.lookup_error_i;
  assign bus.rsp_id_o    = rsp_valid_q ? id_q    : bus.lookup_id_i;

  assign bus.refill_addr_o  = {line_q, {LINE_ALIGN{1'b0}}};
  assign bus.refill_valid_o = refill_valid_q;
  assign bus.refill_ready_o = refill_ready_q;

  assign bus.write_addr_o  = line_q[COUNT_ALIGN-1:0];
  assign bus.write_tag_o   = line_q[LINE_AW-1:COUNT_ALIGN];
  assign bus.write_set_o   = victim_q;
  assign bus.write_data_o  = data_q;
  assign bus.write_error_o = error_q;
  assign bus.write_valid_o = write_valid_q;

  logic unused_lookup;
  assign unused_lookup = ^{bus.lookup_addr_i[LINE_ALIGN-1:0], bus.lookup_set_i};

endmodule
`default_nettype wire
